reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- Architectural register file that sources the two ALU operands and sinks the ALU result on write-back.
- Two combinational read ports feed the ALU A/B inputs; one synchronous write port captures the ALU RESULT at the end of the single cycle.
- Also latches the ALU status outputs (OVERFLOW, ZERO, COUT) into a flag register for later branch and compare use.

Parameters:
- DATA_W, 32, register and data width in bits.
- ADDR_W, 5, register address width; register count is 2**ADDR_W.
- BYPASS, 1, 1 = a read of the register being written this cycle returns WD; 0 = returns the old contents.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- RA1  in  ADDR_W  read address for port 1 (ALU A operand).
- RA2  in  ADDR_W  read address for port 2 (ALU B operand).
- RD1  out  DATA_W  read data, port 1.
- RD2  out  DATA_W  read data, port 2.
- WE  in  1  write enable.
- WA  in  ADDR_W  write address.
- WD  in  DATA_W  write data (ALU RESULT or load data).
- FLAG_WE  in  1  flag register update enable.
- OVERFLOW_IN  in  1  ALU overflow.
- ZERO_IN  in  1  ALU zero.
- COUT_IN  in  1  ALU carry out.
- FLAGS  out  3  latched flags: {OVERFLOW, ZERO, COUT}.

Behaviour:
- Reset:
  - RESET high clears all registers and FLAGS to 0 immediately, with no clock required.
  - RD1 and RD2 then read 0 for every address.
  - RESET asserted mid-write: the write is lost and the register stays 0.
  - RESET deasserted: the first write takes effect on the first rising edge where RESET is low.
- Write:
  - On the rising edge, if WE=1 and WA!=0, then reg[WA] <= WD.
  - Writes to address 0 are discarded; reg[0] always reads 0.
  - WE=0: no register changes, whatever WA and WD are.
- Read:
  - Combinational, zero latency: RD1 = reg[RA1], RD2 = reg[RA2].
  - RA=0 always returns 0, including under bypass.
- Bypass (BYPASS=1):
  - If WE=1, WA!=0 and RAx==WA, then RDx = WD in the same cycle.
  - Applies independently to each port; both ports may bypass at once when RA1==RA2==WA.
- No bypass (BYPASS=0): RDx shows the old value until after the edge.
- Flags:
  - On the rising edge, if FLAG_WE=1, FLAGS <= {OVERFLOW_IN, ZERO_IN, COUT_IN}; otherwise FLAGS hold.
  - FLAGS are never bypassed: the new value is visible the cycle after the update.
- Simultaneous events:
  - WE and FLAG_WE in the same cycle both take effect.
  - A read and a write to the same address follow the BYPASS rule.
  - RA1==RA2 returns identical data on both ports.
- No X propagation: every address is in range (2**ADDR_W entries), so no out-of-bounds case exists.
- Widths: WD is stored unmodified; there is no sign or zero extension inside this block.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W defaults.
  - REG_ZERO = 0.
  - The flag bit indices: FLAG_OVF=2, FLAG_ZERO=1, FLAG_COUT=0, so the decoder and branch logic index FLAGS consistently.
- One sub-module: reg_file_read_port (address decode, zero-register gate, bypass mux), instantiated twice. Storage and flag register stay in the top.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert RESET asynchronously mid-cycle -> RD1 (RA1=5) reads 0x00000000 with no clock edge; FLAGS=3'b000.
- Basic write/read: WE=1, WA=7, WD=0x12345678, edge; then RA1=7, RA2=7 -> RD1=RD2=0x12345678; other registers still 0.
- Zero register: WE=1, WA=0, WD=0xFFFFFFFF, edge -> RA1=0 gives RD1=0. In the same cycle with RA2=0, RD2=0 (no bypass on r0).
- Bypass: r3=0x00000011; in one cycle set WE=1, WA=3, WD=0x00000022, RA1=3, RA2=3.
  - BYPASS=1: RD1=RD2=0x00000022 before the edge.
  - BYPASS=0: RD1=RD2=0x00000011 before the edge, 0x00000022 after.
- WE gating: WE=0, WA=4, WD=0xAAAA5555, edge -> r4 stays 0.
- Flags: FLAG_WE=1, OVERFLOW_IN=1, ZERO_IN=0, COUT_IN=1, edge -> FLAGS=3'b101. Next cycle FLAG_WE=0 with inputs 3'b010 -> FLAGS stays 3'b101.

Source files
------------

// File: rtl/reg_file_2r1w_pkg.sv
// reg_file_2r1w shared constants: default widths, zero register, flag bits.
// No ports; imported by the register file, its read port and interface.
package reg_file_2r1w_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_COUT = 0;
  localparam int FLAG_W    = 3;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/reg_file_2r1w_if.sv
// Register file bus: two read ports, one write port, ALU flag inputs.
// master = ALU/decoder side, slave = register file.
interface reg_file_2r1w_if
  import reg_file_2r1w_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic [ADDR_W-1:0] RA1;
  logic [ADDR_W-1:0] RA2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic              WE;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] WD;
  logic              FLAG_WE;
  logic              OVERFLOW_IN;
  logic              ZERO_IN;
  logic              COUT_IN;
  flags_t            FLAGS;

  modport master (
    output RA1, RA2, WE, WA, WD,
    output FLAG_WE, OVERFLOW_IN,
    output ZERO_IN, COUT_IN,
    input  RD1, RD2, FLAGS
  );

  modport slave (
    input  RA1, RA2, WE, WA, WD,
    input  FLAG_WE, OVERFLOW_IN,
    input  ZERO_IN, COUT_IN,
    output RD1, RD2, FLAGS
  );

endinterface

// File: rtl/reg_file_2r1w_read_port.sv
// One combinational read port: decode, r0 gate, optional write bypass.
// Ports: ra, regs (all entries), we/wa/wd (write port), rd.
module reg_file_read_port
  import reg_file_2r1w_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] ra,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
);

  logic is_zero;
  logic hit;

  assign is_zero = (ra == ADDR_W'(REG_ZERO));

  // wa!=0 keeps hit and is_zero mutually exclusive
  assign hit = (BYPASS != 0) && we
             && (wa == ra)
             && (wa != ADDR_W'(REG_ZERO));

  always_comb begin
    rd = '0;
    unique case (1'b1)
      is_zero: rd = '0;
      hit:     rd = wd;
      default: rd = regs[ra];
    endcase
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// 2-read/1-write register file with r0 hardwired to zero and flag latch.
// Ports: CLK, RESET (async, high), bus (slave: read, write, flag signals).
module reg_file_2r1w
  import reg_file_2r1w_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BYPASS = 1
) (
  input logic CLK,
  input logic RESET,
  reg_file_2r1w_if.slave bus
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] mem;
  flags_t flags_q;

  logic wr_en;

  assign wr_en = bus.WE
              && (bus.WA != ADDR_W'(REG_ZERO));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[bus.WA] <= bus.WD;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      flags_q <= '0;
    end else if (bus.FLAG_WE) begin
      flags_q[FLAG_OVF]  <= bus.OVERFLOW_IN;
      flags_q[FLAG_ZERO] <= bus.ZERO_IN;
      flags_q[FLAG_COUT] <= bus.COUT_IN;
    end
  end

  assign bus.FLAGS = flags_q;

  reg_file_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) u_rp1 (
    .ra  (bus.RA1),
    .regs(mem),
    .we  (bus.WE),
    .wa  (bus.WA),
    .wd  (bus.WD),
    .rd  (bus.RD1)
  );

  reg_file_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) u_rp2 (
    .ra  (bus.RA2),
    .regs(mem),
    .we  (bus.WE),
    .wa  (bus.WA),
    .wd  (bus.WD),
    .rd  (bus.RD2)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench: bypass and no-bypass instances driven in lockstep.
// Vector table, reset corner sequences, then random vs. array model.
module tb_reg_file_2r1w;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  logic [4:0]  ra1, ra2, wa;
  logic [31:0] wd;
  logic        we, fwe;
  logic [2:0]  fin;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];
  logic [2:0]  mflags;

  always #5 CLK = ~CLK;

  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();
  reg_file_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

  assign bus_b.RA1 = ra1;
  assign bus_b.RA2 = ra2;
  assign bus_b.WE = we;
  assign bus_b.WA = wa;
  assign bus_b.WD = wd;
  assign bus_b.FLAG_WE = fwe;
  assign bus_b.OVERFLOW_IN = fin[2];
  assign bus_b.ZERO_IN = fin[1];
  assign bus_b.COUT_IN = fin[0];
  assign bus_n.RA1 = ra1;
  assign bus_n.RA2 = ra2;
  assign bus_n.WE = we;
  assign bus_n.WA = wa;
  assign bus_n.WD = wd;
  assign bus_n.FLAG_WE = fwe;
  assign bus_n.OVERFLOW_IN = fin[2];
  assign bus_n.ZERO_IN = fin[1];
  assign bus_n.COUT_IN = fin[0];

  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b)
  );
  reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) dut_n (
    .CLK(CLK), .RESET(RESET), .bus(bus_n)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        fwe;
    logic [2:0]  fin;
    logic [31:0] b1, b2, n1, n2;
    logic [2:0]  flags;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra,
                                         input bit byp);
    if (ra == 0) return 32'h0;
    if (byp && we && wa == ra) return wd;
    return model[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    mflags = 3'b000;
  endtask

  task automatic model_commit();
    if (we && wa != 0) model[wa] = wd;
    if (fwe) mflags = fin;
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; fwe = 0; fin = 0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    idle();
    tick();
    RESET = 1'b0;
    model_clear();
  endtask

  initial begin
    ra1 = 0; ra2 = 0;
    idle();
    model_clear();
    tick(); tick();
    RESET = 1'b0;

    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      chk("rst_rd1", bus_b.RD1, 32'h0);
      chk("rst_rd2", bus_n.RD2, 32'h0);
    end
    chk("rst_flags", 32'(bus_b.FLAGS), 32'h0);

    vt[0] = '{1,7,32'h12345678,7,7,0,3'b000,
              32'h12345678,32'h12345678,0,0,3'b000};
    vt[1] = '{0,0,0,7,1,0,3'b000,
              32'h12345678,0,32'h12345678,0,3'b000};
    vt[2] = '{1,0,32'hFFFFFFFF,0,0,0,3'b000,
              0,0,0,0,3'b000};
    vt[3] = '{1,3,32'h11,0,5,1,3'b101,
              0,0,0,0,3'b101};
    vt[4] = '{1,3,32'h22,3,3,0,3'b010,
              32'h22,32'h22,32'h11,32'h11,3'b101};
    vt[5] = '{0,4,32'hAAAA5555,3,4,0,3'b000,
              32'h22,0,32'h22,0,3'b101};
    vt[6] = '{0,0,0,4,0,1,3'b010,
              0,0,0,0,3'b010};
    vt[7] = '{1,31,32'h80000001,31,7,1,3'b111,
              32'h80000001,32'h12345678,0,32'h12345678,3'b111};
    vt[8] = '{0,0,0,31,31,0,3'b000,
              32'h80000001,32'h80000001,
              32'h80000001,32'h80000001,3'b111};

    for (int i = 0; i < 9; i++) begin
      we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
      ra1 = vt[i].ra1; ra2 = vt[i].ra2;
      fwe = vt[i].fwe; fin = vt[i].fin;
      #3;
      chk($sformatf("vec%0d_b_rd1", i), bus_b.RD1, vt[i].b1);
      chk($sformatf("vec%0d_b_rd2", i), bus_b.RD2, vt[i].b2);
      chk($sformatf("vec%0d_n_rd1", i), bus_n.RD1, vt[i].n1);
      chk($sformatf("vec%0d_n_rd2", i), bus_n.RD2, vt[i].n2);
      tick();
      chk($sformatf("vec%0d_flags", i),
          32'(bus_b.FLAGS), 32'(vt[i].flags));
      chk($sformatf("vec%0d_flags_n", i),
          32'(bus_n.FLAGS), 32'(vt[i].flags));
    end
    idle();
    ra1 = 3; ra2 = 3;
    #1;
    chk("nobyp_after_edge", bus_n.RD1, 32'h22);

    // async reset mid-cycle after writing r5
    we = 1; wa = 5; wd = 32'hDEADBEEF;
    tick();
    idle();
    ra1 = 5;
    #1;
    chk("r5_written", bus_b.RD1, 32'hDEADBEEF);
    #2;
    RESET = 1'b1;
    #1;
    chk("async_rst_rd1", bus_b.RD1, 32'h0);
    chk("async_rst_rd1_n", bus_n.RD1, 32'h0);
    chk("async_rst_flags", 32'(bus_b.FLAGS), 32'h0);

    // write across a reset edge is lost
    we = 1; wa = 6; wd = 32'h0BADF00D; ra1 = 6;
    tick();
    RESET = 1'b0;
    idle();
    #1;
    chk("rst_write_lost", bus_b.RD1, 32'h0);

    // first write after release lands on first edge
    we = 1; wa = 9; wd = 32'hCAFE0009;
    tick();
    idle();
    ra1 = 9; ra2 = 9;
    #1;
    chk("first_write_rd1", bus_n.RD1, 32'hCAFE0009);
    chk("first_write_rd2", bus_b.RD2, 32'hCAFE0009);

    do_reset();
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      fwe = 1'($urandom_range(0, 1));
      fin = 3'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? wa
          : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1
          : 5'($urandom_range(0, 31));
      #3;
      chk("rnd_b_rd1", bus_b.RD1, exp_rd(ra1, 1));
      chk("rnd_b_rd2", bus_b.RD2, exp_rd(ra2, 1));
      chk("rnd_n_rd1", bus_n.RD1, exp_rd(ra1, 0));
      chk("rnd_n_rd2", bus_n.RD2, exp_rd(ra2, 0));
      tick();
      model_commit();
      chk("rnd_flags", 32'(bus_b.FLAGS), 32'(mflags));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
